// File: rtl/pwm_rgb_bz_gen.sv
// ---------------------------------------------------------------------------
// pwm_rgb_bz_gen
//
// Takes the period register and the four duty registers written by the MCU in
// the FlexBus clock domain and brings them into the PWM clock domain. From
// them it builds four glitch-free, edge-aligned PWM outputs (buzzer and
// red/green/blue LED). A new register set takes effect only at a period
// boundary, or at once while the generator is stopped or parked.
//
// Ports:
//   CLK            PWM time base, rising edge
//   RST_n          asynchronous, active-low reset
//   EN             run enable (synchronous to CLK)
//   FREQ_Cnt_Reg   period in CLK cycles (low CNT_W bits used)
//   BZ_Puty_Reg    buzzer high-time in CLK cycles
//   LEDR_Puty_Reg  red high-time
//   LEDG_Puty_Reg  green high-time
//   LEDB_Puty_Reg  blue high-time
//   BZ_PWM         buzzer PWM
//   LEDR_PWM       red PWM
//   LEDG_PWM       green PWM
//   LEDB_PWM       blue PWM
//   PERIOD_TICK    one-CLK pulse in the cycle the counter shows 0 in RUN
//   CNT            current period counter (debug/readback)
//
// Build option:
//   PWM_ACTIVE_LOW_EN  when defined, the four PWM outputs are inverted
//                      (active level 0, inactive/reset level 1).
//                      PERIOD_TICK and CNT are unaffected.
// ---------------------------------------------------------------------------
module pwm_rgb_bz_gen #(
  parameter int CNT_W      = 32,
  parameter int MIN_PERIOD = 2,
  parameter int STABLE_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             EN,
  input  logic [31:0]      FREQ_Cnt_Reg,
  input  logic [31:0]      BZ_Puty_Reg,
  input  logic [31:0]      LEDR_Puty_Reg,
  input  logic [31:0]      LEDG_Puty_Reg,
  input  logic [31:0]      LEDB_Puty_Reg,
  output logic             BZ_PWM,
  output logic             LEDR_PWM,
  output logic             LEDG_PWM,
  output logic             LEDB_PWM,
  output logic             PERIOD_TICK,
  output logic [CNT_W-1:0] CNT
);

  localparam int SW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
  localparam logic [SW-1:0]    STAB_MAX = SW'(STABLE_CYC);
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PARK = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Word 0 is the period, words 1..4 are the buzzer/R/G/B duties.
  logic [4:0][CNT_W-1:0] in_word;
  logic [4:0][CNT_W-1:0] s1;
  logic [4:0][CNT_W-1:0] s2;
  logic [4:0][CNT_W-1:0] pending;
  logic [SW-1:0]         stab;

  logic [CNT_W-1:0]      period_sh;
  logic [3:0][CNT_W-1:0] duty_sh;

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  terminal;
  logic                  load;
  logic [3:0]            pwm_q;
  logic [3:0]            pwm_next;

  assign in_word = {LEDB_Puty_Reg[CNT_W-1:0], LEDG_Puty_Reg[CNT_W-1:0],
                    LEDR_Puty_Reg[CNT_W-1:0], BZ_Puty_Reg[CNT_W-1:0],
                    FREQ_Cnt_Reg[CNT_W-1:0]};

  // Two-stage sampling of the whole register bundle. The bundle is only
  // trusted once it has been seen unchanged for STABLE_CYC consecutive
  // compares, so a write caught half-way through (torn across words or bits)
  // never reaches the pending set.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s1      <= '0;
      s2      <= '0;
      stab    <= '0;
      pending <= '0;
    end else begin
      s1 <= in_word;
      s2 <= s1;
      if (s1 == s2) begin
        if (stab != STAB_MAX)
          stab <= stab + SW'(1);
      end else begin
        stab <= '0;
      end
      if (stab == STAB_MAX)
        pending <= s2;
    end
  end

  assign terminal = (state == RUN) && (cnt == period_sh - CNT_W'(1));

  // Next-state, counter and output decode. The shadows reload only at the
  // end of a period, while stopped, or while parked, so a running period
  // never sees its period or duty change under it. A period that ends with
  // a too-short pending period drops into PARK instead of running it.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    cnt_next   = '0;
    pwm_next   = '0;

    case (state)
      IDLE: begin
        if (EN)
          next_state = (period_sh >= MIN_P) ? RUN : PARK;
      end
      PARK: begin
        if (!EN)
          next_state = IDLE;
        else if (period_sh >= MIN_P)
          next_state = RUN;
      end
      RUN: begin
        if (!EN)
          next_state = IDLE;
        else if (terminal && (pending[0] < MIN_P))
          next_state = PARK;
      end
      default: next_state = IDLE;
    endcase

    load = !EN || (state == PARK) || terminal;

    if ((state == RUN) && (next_state == RUN) && !terminal)
      cnt_next = cnt + CNT_W'(1);

    // The output flop carries the compare of the counter it saw, so it lags
    // CNT by one clock; leaving RUN forces it inactive on the very next cycle.
    for (int i = 0; i < 4; i++)
      pwm_next[i] = (state == RUN) && (next_state == RUN) && (cnt < duty_sh[i]);
  end

  // State, counter, shadows and the registered PWM levels.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      cnt       <= '0;
      period_sh <= '0;
      duty_sh   <= '0;
      pwm_q     <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      pwm_q <= pwm_next;
      if (load) begin
        period_sh <= pending[0];
        duty_sh   <= pending[4:1];
      end
    end
  end

  assign PERIOD_TICK = (state == RUN) && (cnt == '0);
  assign CNT         = cnt;

`ifdef PWM_ACTIVE_LOW_EN
  assign {LEDB_PWM, LEDG_PWM, LEDR_PWM, BZ_PWM} = ~pwm_q;
`else
  assign {LEDB_PWM, LEDG_PWM, LEDR_PWM, BZ_PWM} = pwm_q;
`endif

endmodule

// File: doc/pwm_rgb_bz_gen.md
Name: pwm_rgb_bz_gen

Overview:
Consumer stage directly downstream of the FlexBus register slave. Takes the period register (FREQ_Cnt_Reg) and four duty registers (buzzer, LED R/G/B) written by the MCU, moves them safely into the PWM clock domain, and generates four glitch-free, edge-aligned PWM outputs. Register changes take effect only at a period boundary.

Parameters:
CNT_W, 32, counter/period/duty width; only low CNT_W bits of each input register are used
MIN_PERIOD, 2, smallest period (in CLK cycles) that runs; smaller values park the outputs
STABLE_CYC, 2, consecutive identical samples required before an input bundle is accepted (>=1)

Ports:
CLK  in  1  PWM time base, rising edge, asynchronous to FB_CLK
RST_n  in  1  reset, asynchronous, active-low
EN  in  1  run enable; synchronous to CLK
FREQ_Cnt_Reg  in  32  period in CLK cycles (FB_CLK domain, quasi-static)
BZ_Puty_Reg  in  32  buzzer high-time in CLK cycles
LEDR_Puty_Reg  in  32  red high-time
LEDG_Puty_Reg  in  32  green high-time
LEDB_Puty_Reg  in  32  blue high-time
BZ_PWM  out  1  buzzer PWM
LEDR_PWM  out  1  red PWM
LEDG_PWM  out  1  green PWM
LEDB_PWM  out  1  blue PWM
PERIOD_TICK  out  1  one-CLK pulse on the cycle cnt wraps to 0
CNT  out  CNT_W  current period counter, for debug/readback

Behaviour:
- Reset (async): all sample/pending/shadow regs 0, cnt 0, stab counter 0, all PWM outputs inactive (0), PERIOD_TICK 0.
- Input capture: 5-word bundle registered into s1 each CLK, s2<=s1. stab counter increments while s1==s2, clears to 0 on mismatch, saturates at STABLE_CYC. pending<=s2 on every cycle stab==STABLE_CYC. Mismatch never updates pending (torn multi-bit writes rejected).
- Shadow load: period_sh/duty_sh<=pending when (a) cnt terminal, (b) EN==0, or (c) parked. Never mid-period.
- States: IDLE (EN=0), PARK (EN=1, period_sh<MIN_PERIOD), RUN.
  IDLE: cnt held 0, outputs inactive, shadows track pending. -> RUN/PARK on EN=1 per period_sh.
  PARK: cnt held 0, outputs inactive, no PERIOD_TICK. -> RUN first cycle period_sh>=MIN_PERIOD; -> IDLE on EN=0.
  RUN: cnt 0..period_sh-1; at period_sh-1 next cnt=0, shadows reload, PERIOD_TICK=1 in the cycle cnt==0 is presented. EN=0 -> IDLE next cycle, outputs inactive next cycle (no waiting for boundary).
- Output: ch_PWM registered = (cnt < duty_sh), unsigned compare; 1 CLK latency from cnt. duty 0 -> constant inactive; duty>=period_sh -> constant active (no 1-cycle dip at wrap).
- First RUN cycle: cnt=0, PERIOD_TICK=1.
- Wrap: cnt never exceeds period_sh-1; CNT_W all-ones period valid.
- Reset mid-period: immediate return to reset state; restart at cnt 0 after release.

Optional Feature:
PWM_ACTIVE_LOW_EN: defined -> all four PWM outputs inverted (active level 0, inactive/reset level 1) for common-anode LEDs and low-side buzzer drive; PERIOD_TICK and CNT unaffected. Undefined -> active-high, reset level 0.

Test Plan:
- Reset release, EN=1, FREQ=10, BZ=3 -> after capture latency, PERIOD_TICK every 10 CLK; BZ_PWM high 3 CLK, low 7 CLK, rising 1 CLK after cnt==0.
- FREQ=10, LEDR=0, LEDG=10, LEDB=15 -> LEDR constant 0, LEDG and LEDB constant 1 across many wraps, no glitch.
- While running FREQ=10 BZ=3, change BZ to 6 at cnt==4 -> current period keeps 3-cycle high; next period (after PERIOD_TICK) 6-cycle high.
- FREQ=1 (<MIN_PERIOD) with EN=1 -> outputs inactive, CNT=0, no PERIOD_TICK; then FREQ=4 -> RUN begins with PERIOD_TICK at cnt 0.
- Input bundle toggled every CLK between two values -> pending never updates, PWM unchanged; hold stable STABLE_CYC+2 cycles -> update applied at next boundary.
- Assert RST_n low at cnt==5 of period 10 -> outputs inactive, CNT=0 asynchronously; with PWM_ACTIVE_LOW_EN outputs go to 1.
